// File: rtl/pipelined_barrel_shifter.sv
// Pipelined WIDTH-bit rotator/shifter: one registered stage per shift-amount bit,
// with a valid/ready handshake and a global stall driven by the output register.
module pipelined_barrel_shifter #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d_in,
  input  logic [SHW-1:0]   n_bits,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d_out
);

  localparam logic [1:0] MODE_ROR = 2'b00;
  localparam logic [1:0] MODE_ROL = 2'b01;
  localparam logic [1:0] MODE_LSR = 2'b10;

  logic advance;

  // ASR fills from the sign captured at stage 0, since later MSBs may already be fill.
  function automatic logic [WIDTH-1:0] moveWord(input logic [WIDTH-1:0] x,
                                                input logic [1:0]       m,
                                                input logic             sgn,
                                                input int unsigned      s);
    logic [2*WIDTH-1:0] dbl;
    dbl = '0;
    case (m)
      MODE_ROR: dbl = {x, x} >> s;
      MODE_ROL: dbl = ({x, x} << s) >> WIDTH;
      MODE_LSR: dbl = {{WIDTH{1'b0}}, x} >> s;
      default:  dbl = {{WIDTH{sgn}}, x} >> s;
    endcase
    return dbl[WIDTH-1:0];
  endfunction

  for (genvar k = 0; k < SHW; k++) begin : gStage
    localparam int unsigned STEP = 1 << k;

    logic [WIDTH-1:0] xIn;
    logic [SHW-k-1:0] amtIn;
    logic [1:0]       modeIn;
    logic             signIn;
    logic             validIn;
    logic [WIDTH-1:0] dataQ;
    logic [WIDTH-1:0] dataD;
    logic             validQ;

    if (k == 0) begin : gFirst
      assign xIn     = d_in;
      assign amtIn   = n_bits;
      assign modeIn  = mode;
      assign signIn  = d_in[WIDTH-1];
      assign validIn = in_valid;
    end else begin : gNext
      assign xIn     = gStage[k-1].dataQ;
      assign amtIn   = gStage[k-1].gCtrl.amtQ;
      assign modeIn  = gStage[k-1].gCtrl.modeQ;
      assign signIn  = gStage[k-1].gCtrl.signQ;
      assign validIn = gStage[k-1].validQ;
    end

    assign dataD = amtIn[0] ? moveWord(xIn, modeIn, signIn, STEP) : xIn;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dataQ  <= '0;
        validQ <= 1'b0;
      end else if (advance) begin
        dataQ  <= dataD;
        validQ <= validIn;
      end
    end

    // Control travels with the word; the last stage has nothing left to forward.
    if (k < SHW - 1) begin : gCtrl
      logic [SHW-k-2:0] amtQ;
      logic [1:0]       modeQ;
      logic             signQ;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          amtQ  <= '0;
          modeQ <= '0;
          signQ <= 1'b0;
        end else if (advance) begin
          amtQ  <= amtIn[SHW-k-1:1];
          modeQ <= modeIn;
          signQ <= signIn;
        end
      end
    end
  end

  assign out_valid = gStage[SHW-1].validQ;
  assign d_out     = gStage[SHW-1].dataQ;
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench: directed cases on an 8-bit instance plus randomized
// valid/ready traffic on 8, 16 and 32-bit instances against an arithmetic model.
module tb_pipelined_barrel_shifter;

  localparam int NINST = 3;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  logic        inValid  [NINST];
  logic        outReady [NINST];
  logic [31:0] dIn      [NINST];
  logic [4:0]  nBits    [NINST];
  logic [1:0]  modeIn   [NINST];
  wire         inReady  [NINST];
  wire         outValid [NINST];
  wire  [31:0] dOut     [NINST];

  int checks = 0;
  int passes = 0;

  logic [31:0] expQ [NINST][$];
  logic        holdValid [NINST];
  logic [31:0] holdData  [NINST];
  int          accCnt    [NINST];
  int          outCnt    [NINST];

  for (genvar gi = 0; gi < NINST; gi++) begin : gW
    localparam int W = 8 << gi;
    localparam int S = $clog2(W);
    logic [W-1:0] dOutL;

    pipelined_barrel_shifter #(.WIDTH(W)) u_dut (
      .clk      (clk),
      .rst_n    (rstN),
      .in_valid (inValid[gi]),
      .in_ready (inReady[gi]),
      .d_in     (dIn[gi][W-1:0]),
      .n_bits   (nBits[gi][S-1:0]),
      .mode     (modeIn[gi]),
      .out_valid(outValid[gi]),
      .out_ready(outReady[gi]),
      .d_out    (dOutL)
    );

    assign dOut[gi] = 32'(dOutL);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Whole-word arithmetic view of each operation, no stage decomposition.
  function automatic logic [31:0] refModel(input int w, input logic [31:0] x, input int n, input logic [1:0] m);
    logic [63:0]        mask;
    logic [63:0]        xv;
    logic [63:0]        r;
    logic signed [63:0] sx;
    mask = (64'd1 << w) - 64'd1;
    xv   = {32'd0, x} & mask;
    sx   = '0;
    case (m)
      2'd0:    r = (xv >> n) | (xv << (w - n));
      2'd1:    r = (xv << n) | (xv >> (w - n));
      2'd2:    r = xv >> n;
      default: begin
        sx = xv[w-1] ? signed'(xv | ~mask) : signed'(xv);
        r  = 64'(sx >>> n);
      end
    endcase
    r = r & mask;
    return r[31:0];
  endfunction

  // Scoreboard: samples every instance mid-cycle, after the bench has driven inputs.
  initial begin
    for (int i = 0; i < NINST; i++) begin
      holdValid[i] = 1'b0;
      holdData[i]  = '0;
      accCnt[i]    = 0;
      outCnt[i]    = 0;
    end
    forever begin
      @(negedge clk);
      #2;
      for (int i = 0; i < NINST; i++) begin
        if (!rstN) begin
          expQ[i].delete();
          holdValid[i] = 1'b0;
          accCnt[i]    = outCnt[i];
          continue;
        end
        if (holdValid[i]) begin
          checkOutput($sformatf("hold_valid_w%0d", 8 << i), 32'(outValid[i]), 32'd1);
          checkOutput($sformatf("hold_data_w%0d", 8 << i), dOut[i], holdData[i]);
        end
        if (outValid[i] && outReady[i]) begin
          outCnt[i]++;
          if (expQ[i].size() == 0)
            checkOutput($sformatf("spurious_out_w%0d", 8 << i), 32'(outCnt[i]), 32'(accCnt[i]));
          else
            checkOutput($sformatf("data_w%0d", 8 << i), dOut[i], expQ[i].pop_front());
        end
        if (inValid[i] && inReady[i]) begin
          expQ[i].push_back(refModel(8 << i, dIn[i], int'(nBits[i]) & ((8 << i) - 1), modeIn[i]));
          accCnt[i]++;
        end
        holdValid[i] = outValid[i] && !outReady[i];
        holdData[i]  = dOut[i];
      end
    end
  end

  task automatic applyStimulus(input int idx, input logic [31:0] d, input int n, input logic [1:0] m,
                               output bit ok);
    inValid[idx] = 1'b1;
    dIn[idx]     = d;
    nBits[idx]   = 5'(n);
    modeIn[idx]  = m;
    ok           = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      #1;
      ok = inReady[idx];
      @(negedge clk);
    end
    inValid[idx] = 1'b0;
  endtask

  task automatic runDirected(input string tag, input logic [31:0] d, input int n, input logic [1:0] m,
                             input logic [31:0] expected);
    bit ok;
    int lat;
    applyStimulus(0, d, n, m, ok);
    checkOutput({tag, "_accept"}, 32'(ok), 32'd1);
    lat = 1;
    #1;
    while (!outValid[0] && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'd3);
    checkOutput({tag, "_data"}, dOut[0], expected);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit hit, %0d of %0d checks passed so far", passes, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] expMode [4];
    int firstV, lastV, vCount;
    expMode = '{8'hD2, 8'hB4, 8'h12, 8'hF2};

    rstN = 1'b0;
    for (int i = 0; i < NINST; i++) begin
      inValid[i]  = 1'b0;
      outReady[i] = 1'b1;
      dIn[i]      = '0;
      nBits[i]    = '0;
      modeIn[i]   = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_out_valid", 32'(outValid[0]), 32'd0);
    checkOutput("reset_d_out", dOut[0], 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checkOutput("idle_in_ready", 32'(inReady[0]), 32'd1);
    @(negedge clk);

    // Reference pattern in each mode, then the boundary amounts.
    for (int m = 0; m < 4; m++)
      runDirected($sformatf("mode%0d", m), 32'h96, 3, 2'(m), 32'(expMode[m]));
    for (int m = 0; m < 4; m++)
      runDirected($sformatf("zero_shift_mode%0d", m), 32'h5A, 0, 2'(m), 32'h5A);
    runDirected("lsr_max", 32'h80, 7, 2'd2, 32'h01);
    runDirected("asr_max", 32'h7F, 7, 2'd3, 32'h00);

    // Back-to-back stream of 16 words at full rate.
    firstV = -1;
    lastV  = -1;
    vCount = 0;
    for (int t = 0; t < 26; t++) begin
      if (t < 16) begin
        inValid[0] = 1'b1;
        dIn[0]     = $urandom;
        nBits[0]   = 5'($urandom_range(0, 7));
        modeIn[0]  = 2'($urandom);
      end else begin
        inValid[0] = 1'b0;
      end
      #1;
      if (t < 16) checkOutput("stream_in_ready", 32'(inReady[0]), 32'd1);
      if (outValid[0]) begin
        vCount++;
        if (firstV < 0) firstV = t;
        lastV = t;
      end
      @(negedge clk);
    end
    checkOutput("stream_count", 32'(vCount), 32'd16);
    checkOutput("stream_first", 32'(firstV), 32'd3);
    checkOutput("stream_span", 32'(lastV - firstV + 1), 32'd16);

    // Output stall with a second word queued behind and inputs offered while stalled.
    inValid[0] = 1'b1; dIn[0] = 32'h81; nBits[0] = 5'd7; modeIn[0] = 2'd3;
    @(negedge clk);
    dIn[0] = 32'h40; nBits[0] = 5'd1; modeIn[0] = 2'd2;
    @(negedge clk);
    inValid[0]  = 1'b0;
    outReady[0] = 1'b0;
    @(negedge clk);
    for (int t = 0; t < 5; t++) begin
      inValid[0] = 1'b1;
      dIn[0]     = $urandom;
      #1;
      checkOutput("stall_out_valid", 32'(outValid[0]), 32'd1);
      checkOutput("stall_d_out", dOut[0], 32'hFF);
      checkOutput("stall_in_ready", 32'(inReady[0]), 32'd0);
      @(negedge clk);
    end
    inValid[0]  = 1'b0;
    outReady[0] = 1'b1;
    #1;
    checkOutput("release_in_ready", 32'(inReady[0]), 32'd1);
    @(negedge clk);
    #1;
    checkOutput("after_stall_valid", 32'(outValid[0]), 32'd1);
    checkOutput("after_stall_data", dOut[0], 32'h20);
    @(negedge clk);
    #1;
    checkOutput("after_stall_bubble", 32'(outValid[0]), 32'd0);
    @(negedge clk);

    // Asynchronous reset with three words in flight.
    for (int w = 0; w < 3; w++) begin
      inValid[0] = 1'b1; dIn[0] = 32'h96; nBits[0] = 5'd3; modeIn[0] = 2'd1;
      if (w < 2) @(negedge clk);
    end
    @(posedge clk);
    #3;
    checkOutput("pre_reset_valid", 32'(outValid[0]), 32'd1);
    checkOutput("pre_reset_data", dOut[0], 32'hB4);
    rstN       = 1'b0;
    inValid[0] = 1'b0;
    #1;
    checkOutput("async_reset_valid", 32'(outValid[0]), 32'd0);
    checkOutput("async_reset_data", dOut[0], 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    for (int t = 0; t < 3; t++) begin
      #1;
      checkOutput("post_reset_idle", 32'(outValid[0]), 32'd0);
      @(negedge clk);
    end
    runDirected("post_reset", 32'h3C, 2, 2'd0, 32'h0F);

    // Random valid/ready traffic on all widths, then drain.
    for (int t = 0; t < 1000; t++) begin
      for (int i = 0; i < NINST; i++) begin
        inValid[i]  = ($urandom_range(0, 3) != 0);
        outReady[i] = ($urandom_range(0, 3) != 0);
        dIn[i]      = $urandom;
        nBits[i]    = 5'($urandom);
        modeIn[i]   = 2'($urandom);
      end
      @(negedge clk);
    end
    for (int i = 0; i < NINST; i++) begin
      inValid[i]  = 1'b0;
      outReady[i] = 1'b1;
    end
    repeat (40) @(negedge clk);
    #3;
    for (int i = 0; i < NINST; i++) begin
      checkOutput($sformatf("drain_balance_w%0d", 8 << i), 32'(outCnt[i]), 32'(accCnt[i]));
      checkOutput($sformatf("drain_empty_w%0d", 8 << i), 32'(outValid[i]), 32'd0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
